// File: rtl/generate_guess_stream.sv
// Brute-force guess generator: odometer enumeration of every string of length 1..MAX_LEN over [CHAR_MIN, CHAR_MAX].
// Optional macro GENERATE_GUESS_SEED_EN enables a loadable starting point (seed) for the enumeration.
module generate_guess_stream #(
    parameter int          MAX_LEN  = 16,
    parameter logic [7:0]  CHAR_MIN = 8'h20,
    parameter logic [7:0]  CHAR_MAX = 8'h7E,
    parameter int          CNT_W    = 48,
    localparam int         LW       = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 guess_ready,
    input  logic                 seed_load,
    input  logic [8*MAX_LEN-1:0] seed_chars,
    input  logic [LW-1:0]        seed_len,
    output logic [8*MAX_LEN-1:0] guess,
    output logic [8*MAX_LEN-1:0] guess_packed,
    output logic [LW-1:0]        guess_len,
    output logic                 guess_valid,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     guess_count
);

    localparam int GW = 8 * MAX_LEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     guess_q, guess_d;
    logic [GW-1:0]     packed_q, packed_d;
    logic [LW-1:0]     len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [GW-1:0]     adv_chars_s;
    logic [LW-1:0]     adv_len_s;
    logic              adv_carry_s;
    logic              adv_final_s;
    logic [GW-1:0]     init_chars_s;
    logic [LW-1:0]     init_len_s;

    // Left-justified view: char i lands in byte (MAX_LEN-1-i); unused chars are zero so lower bytes stay zero.
    function automatic logic [GW-1:0] byte_reverse(input logic [GW-1:0] v);
        logic [GW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            r[8*(MAX_LEN-1-i) +: 8] = v[8*i +: 8];
        end
        return r;
    endfunction

`ifdef GENERATE_GUESS_SEED_EN
    logic [GW-1:0] seed_chars_q, seed_chars_d;
    logic [LW-1:0] seed_len_q, seed_len_d;

    // Sanitize and capture a seed while not enumerating
    always_comb begin
        seed_chars_d = seed_chars_q;
        seed_len_d   = seed_len_q;
        if (seed_load && (state_q != S_RUN)) begin
            if ((seed_len == '0) || (int'(seed_len) > MAX_LEN)) begin
                seed_len_d = LW'(1);
            end else begin
                seed_len_d = seed_len;
            end
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i >= int'(seed_len_d)) begin
                    seed_chars_d[8*i +: 8] = 8'h00;
                end else if ((seed_chars[8*i +: 8] < CHAR_MIN) || (seed_chars[8*i +: 8] > CHAR_MAX)) begin
                    seed_chars_d[8*i +: 8] = CHAR_MIN;
                end else begin
                    seed_chars_d[8*i +: 8] = seed_chars[8*i +: 8];
                end
            end
        end else begin
            seed_len_d = seed_len_q;
        end
    end

    // Seed storage
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            seed_chars_q      <= '0;
            seed_chars_q[7:0] <= CHAR_MIN;
            seed_len_q        <= LW'(1);
        end else begin
            seed_chars_q <= seed_chars_d;
            seed_len_q   <= seed_len_d;
        end
    end

    assign init_chars_s = seed_chars_q;
    assign init_len_s   = seed_len_q;
`else
    logic unused_s;
    assign unused_s = ^{seed_load, seed_chars, seed_len};

    // Fixed starting point: a single CHAR_MIN
    always_comb begin
        init_chars_s      = '0;
        init_chars_s[7:0] = CHAR_MIN;
        init_len_s        = LW'(1);
    end
`endif

    // Odometer successor of the current guess; a carry out of the full-length guess marks the final one
    always_comb begin
        adv_chars_s = guess_q;
        adv_len_s   = len_q;
        adv_carry_s = 1'b1;
        adv_final_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (adv_carry_s && (i < int'(len_q))) begin
                if (guess_q[8*i +: 8] == CHAR_MAX) begin
                    adv_chars_s[8*i +: 8] = CHAR_MIN;
                end else begin
                    adv_chars_s[8*i +: 8] = guess_q[8*i +: 8] + 8'd1;
                    adv_carry_s           = 1'b0;
                end
            end else begin
                adv_carry_s = adv_carry_s;
            end
        end
        if (adv_carry_s) begin
            if (int'(len_q) < MAX_LEN) begin
                adv_len_s = len_q + LW'(1);
                for (int i = 0; i < MAX_LEN; i++) begin
                    adv_chars_s[8*i +: 8] = (i <= int'(len_q)) ? CHAR_MIN : 8'h00;
                end
            end else begin
                adv_chars_s = guess_q;
                adv_final_s = 1'b1;
            end
        end else begin
            adv_final_s = 1'b0;
        end
    end

    // Control FSM and datapath next state; stop overrides everything including an accept
    always_comb begin
        state_d = state_q;
        guess_d = guess_q;
        len_d   = len_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !stop) begin
                    state_d = S_RUN;
                    guess_d = init_chars_s;
                    len_d   = init_len_s;
                    count_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (guess_ready) begin
                    guess_d = adv_chars_s;
                    len_d   = adv_len_s;
                    count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
                    state_d = adv_final_s ? S_DONE : S_RUN;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        packed_d = byte_reverse(guess_d);
        valid_d  = (state_d == S_RUN);
        busy_d   = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
    end

    // State, guess and status registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            guess_q  <= '0;
            packed_q <= '0;
            len_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            packed_q <= packed_d;
            len_q    <= len_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign guess        = guess_q;
    assign guess_packed = packed_q;
    assign guess_len    = len_q;
    assign guess_valid  = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign guess_count  = count_q;

endmodule

// File: tb/tb_generate_guess_stream.sv
// Directed, table-driven bench for generate_guess_stream with charset 'a'..'c', MAX_LEN=2.
// A second instance with a 3-bit counter checks count saturation.
module tb_generate_guess_stream;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start, stop, guess_ready, seed_load;
    logic [15:0] seed_chars;
    logic [1:0]  seed_len;

    logic [15:0] guess, guess_packed;
    logic [1:0]  guess_len;
    logic        guess_valid, busy, done;
    logic [7:0]  guess_count;

    logic [15:0] s_guess, s_packed;
    logic [1:0]  s_len;
    logic        s_valid, s_busy, s_done;
    logic [2:0]  s_count;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    generate_guess_stream #(.MAX_LEN(2), .CHAR_MIN(8'h61), .CHAR_MAX(8'h63), .CNT_W(8)) u_dut (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .guess_ready(guess_ready),
        .seed_load(seed_load), .seed_chars(seed_chars), .seed_len(seed_len),
        .guess(guess), .guess_packed(guess_packed), .guess_len(guess_len),
        .guess_valid(guess_valid), .busy(busy), .done(done), .guess_count(guess_count)
    );

    generate_guess_stream #(.MAX_LEN(2), .CHAR_MIN(8'h61), .CHAR_MAX(8'h63), .CNT_W(3)) u_sat (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .guess_ready(guess_ready),
        .seed_load(seed_load), .seed_chars(seed_chars), .seed_len(seed_len),
        .guess(s_guess), .guess_packed(s_packed), .guess_len(s_len),
        .guess_valid(s_valid), .busy(s_busy), .done(s_done), .guess_count(s_count)
    );

    typedef struct {
        logic        start, stop, ready;
        logic        valid, busy, done;
        logic [15:0] g, p;
        logic [1:0]  len;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic rd,
                       input logic v, input logic b, input logic d,
                       input logic [15:0] g, input logic [15:0] p,
                       input logic [1:0] l, input logic [7:0] c);
        vec_t t;
        t.start = st; t.stop = sp; t.ready = rd;
        t.valid = v; t.busy = b; t.done = d;
        t.g = g; t.p = p; t.len = l; t.cnt = c;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic b, input logic d,
                           input logic [15:0] g, input logic [15:0] p,
                           input logic [1:0] l, input logic [7:0] c);
        chk({tag, ".valid"}, 32'(guess_valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".guess"}, 32'(guess), 32'(g));
        chk({tag, ".packed"}, 32'(guess_packed), 32'(p));
        chk({tag, ".len"}, 32'(guess_len), 32'(l));
        chk({tag, ".count"}, 32'(guess_count), 32'(c));
        chk({tag, ".satcount"}, 32'(s_count), (c > 8'd7) ? 32'd7 : 32'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_rst = 1'b0; start = 1'b0; stop = 1'b0; guess_ready = 1'b0;
        seed_load = 1'b0; seed_chars = 16'h0000; seed_len = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 8'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("idle", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 8'd0);

        // start stop rdy | valid busy done | guess packed len count
        add(1, 0, 1,  1, 1, 0,  16'h0061, 16'h6100, 2'd1, 8'd0);
        add(0, 0, 1,  1, 1, 0,  16'h0062, 16'h6200, 2'd1, 8'd1);
        add(0, 0, 1,  1, 1, 0,  16'h0063, 16'h6300, 2'd1, 8'd2);
        add(0, 0, 1,  1, 1, 0,  16'h6161, 16'h6161, 2'd2, 8'd3);
        add(0, 0, 1,  1, 1, 0,  16'h6162, 16'h6261, 2'd2, 8'd4);
        for (int k = 0; k < 5; k++) begin
            add(0, 0, 0,  1, 1, 0,  16'h6162, 16'h6261, 2'd2, 8'd4);
        end
        add(1, 0, 1,  1, 1, 0,  16'h6163, 16'h6361, 2'd2, 8'd5);
        add(0, 0, 1,  1, 1, 0,  16'h6261, 16'h6162, 2'd2, 8'd6);
        add(0, 0, 1,  1, 1, 0,  16'h6262, 16'h6262, 2'd2, 8'd7);
        add(0, 0, 1,  1, 1, 0,  16'h6263, 16'h6362, 2'd2, 8'd8);
        add(0, 0, 1,  1, 1, 0,  16'h6361, 16'h6163, 2'd2, 8'd9);
        add(0, 0, 1,  1, 1, 0,  16'h6362, 16'h6263, 2'd2, 8'd10);
        add(0, 0, 1,  1, 1, 0,  16'h6363, 16'h6363, 2'd2, 8'd11);
        add(0, 0, 1,  0, 0, 1,  16'h6363, 16'h6363, 2'd2, 8'd12);
        add(0, 0, 1,  0, 0, 1,  16'h6363, 16'h6363, 2'd2, 8'd12);
        add(1, 1, 1,  0, 0, 1,  16'h6363, 16'h6363, 2'd2, 8'd12);
        add(1, 0, 0,  1, 1, 0,  16'h0061, 16'h6100, 2'd1, 8'd0);
        add(0, 1, 0,  0, 0, 0,  16'h0061, 16'h6100, 2'd1, 8'd0);
        add(1, 1, 0,  0, 0, 0,  16'h0061, 16'h6100, 2'd1, 8'd0);
        add(1, 0, 0,  1, 1, 0,  16'h0061, 16'h6100, 2'd1, 8'd0);
        add(0, 0, 1,  1, 1, 0,  16'h0062, 16'h6200, 2'd1, 8'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; stop = vecs[i].stop; guess_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].valid, vecs[i].busy, vecs[i].done,
                    vecs[i].g, vecs[i].p, vecs[i].len, vecs[i].cnt);
        end
        start = 1'b0; stop = 1'b0; guess_ready = 1'b0;

        // Asynchronous reset mid-RUN, checked before the next clock edge
        #2;
        n_rst = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 8'd0);
        @(negedge clk);
        n_rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_all("post_rst", 1'b1, 1'b1, 1'b0, 16'h0061, 16'h6100, 2'd1, 8'd0);

        // Full enumeration at one guess per clock, bounded
        guess_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        guess_ready = 1'b0;
        chk("run.cycles", 32'(n), 32'd12);
        chk_all("run.end", 1'b0, 1'b0, 1'b1, 16'h6363, 16'h6363, 2'd2, 8'd12);

        // Seed "cb" loaded in DONE
        seed_load = 1'b1; seed_chars = 16'h6263; seed_len = 2'd2;
        @(posedge clk);
        #1;
        seed_load = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef GENERATE_GUESS_SEED_EN
        chk_all("seed1", 1'b1, 1'b1, 1'b0, 16'h6263, 16'h6362, 2'd2, 8'd0);
`else
        chk_all("seed1", 1'b1, 1'b1, 1'b0, 16'h0061, 16'h6100, 2'd1, 8'd0);
`endif
        guess_ready = 1'b1;
        @(posedge clk);
        #1;
        guess_ready = 1'b0;
`ifdef GENERATE_GUESS_SEED_EN
        chk("seed1.next", 32'(guess), 32'h6361);
`else
        chk("seed1.next", 32'(guess), 32'h0062);
`endif
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("seed1.stop", 32'(guess_valid), 32'd0);

        // Out-of-range seed char becomes CHAR_MIN
        seed_load = 1'b1; seed_chars = 16'h007A; seed_len = 2'd1;
        @(posedge clk);
        #1;
        seed_load = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_all("seed2", 1'b1, 1'b1, 1'b0, 16'h0061, 16'h6100, 2'd1, 8'd0);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;

        // Oversized seed length stored as 1; a later load during RUN is ignored
        seed_load = 1'b1; seed_chars = 16'h6263; seed_len = 2'd3;
        @(posedge clk);
        #1;
        seed_load = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef GENERATE_GUESS_SEED_EN
        chk_all("seed3", 1'b1, 1'b1, 1'b0, 16'h0063, 16'h6300, 2'd1, 8'd0);
`else
        chk_all("seed3", 1'b1, 1'b1, 1'b0, 16'h0061, 16'h6100, 2'd1, 8'd0);
`endif
        seed_load = 1'b1; seed_chars = 16'h0062; seed_len = 2'd1;
        @(posedge clk);
        #1;
        seed_load = 1'b0; stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef GENERATE_GUESS_SEED_EN
        chk("seed4.guess", 32'(guess), 32'h0063);
`else
        chk("seed4.guess", 32'(guess), 32'h0061);
`endif
        chk("seed4.len", 32'(guess_len), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/generate_guess_stream.md
GENERATE_GUESS_STREAM -- requirements
Module: generate_guess_stream

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum guess length in characters, 1..16.
REQ-002 Parameter CHAR_MIN, default 8'h20: lowest character of the charset.
REQ-003 Parameter CHAR_MAX, default 8'h7E: highest character of the charset; CHAR_MAX > CHAR_MIN.
REQ-004 Parameter CNT_W, default 48: width of the guess counter.
REQ-005 Ports: clk in 1 clock; n_rst in 1 asynchronous active-low reset. One clock; reset is asynchronous and active-low.
REQ-006 start in 1: pulse that begins enumeration; stop in 1: pulse that aborts enumeration.
REQ-007 guess_ready in 1: consumer accepts the current guess.
REQ-008 seed_load in 1; seed_chars in 8*MAX_LEN; seed_len in LW, where LW = $clog2(MAX_LEN+1): starting-point load.
REQ-009 guess out 8*MAX_LEN: char i in bits [8i+7:8i]; bytes at index >= guess_len are zero.
REQ-010 guess_packed out 8*MAX_LEN: left-justified copy; char i in byte (MAX_LEN-1-i); lower bytes are zero.
REQ-011 guess_len out LW; guess_valid out 1; busy out 1; done out 1; guess_count out CNT_W.

Function
REQ-012 FSM states: IDLE, RUN, DONE. IDLE->RUN on start; RUN->IDLE on stop; RUN->DONE when the final guess is accepted; DONE->RUN on start.
REQ-013 Same-cycle start and stop: stop wins. start in RUN is ignored.
REQ-014 On the transition into RUN, the guess is loaded from the initial value: length 1, char0 = CHAR_MIN (or the seed, per REQ-026). guess_count is cleared to 0.
REQ-015 guess_valid = 1 only in RUN. busy = 1 in RUN. done = 1 only in DONE.
REQ-016 Accept = guess_valid & guess_ready. Each accept advances the guess on the next clock edge. Without an accept, guess, guess_packed and guess_len hold stable.
REQ-017 Advance (odometer): char0 is least significant. A char below CHAR_MAX increments by 1 and stops the carry. A char at CHAR_MAX wraps to CHAR_MIN and carries to the next index.
REQ-018 Carry out of index guess_len-1 with guess_len < MAX_LEN: guess_len+1, and all chars become CHAR_MIN.
REQ-019 Final guess: guess_len = MAX_LEN and every char = CHAR_MAX. Accepting it enters DONE; guess holds its last value and guess_valid drops.
REQ-020 guess_count increments on each accept and saturates at all-ones.
REQ-021 guess_packed and guess are registered together and never disagree in any cycle.
REQ-022 Latency: first guess_valid appears in the cycle after start is sampled. Sustained throughput is one guess per clock while guess_ready = 1.

Reset
REQ-023 n_rst low, at any time including mid-RUN: state = IDLE; guess = 0, guess_packed = 0, guess_len = 0, guess_valid = 0, busy = 0, done = 0, guess_count = 0.
REQ-024 The stored seed resets to length 1, char0 = CHAR_MIN.
REQ-025 The first start after reset release behaves per REQ-014.

Configuration
REQ-026 Macro GENERATE_GUESS_SEED_EN defined:
- seed_load sampled in IDLE or DONE stores seed_chars and seed_len; seed_load is ignored in RUN.
- Every stored char outside [CHAR_MIN, CHAR_MAX] is replaced by CHAR_MIN.
- seed_len of 0 or > MAX_LEN is stored as 1.
- Subsequent starts begin from the stored seed.
REQ-027 Macro GENERATE_GUESS_SEED_EN undefined: the seed ports exist but are ignored, and enumeration always begins per REQ-014.

Verification
REQ-028 MAX_LEN=2, CHAR_MIN=8'h61, CHAR_MAX=8'h63, guess_ready=1, start pulse -> guesses a,b,c,aa,ba,ca,ab,...,cc (12 guesses) -> DONE, done=1, guess_count=12.
REQ-029 Same config, guess="ba" -> guess[15:0]=16'h6162, guess_packed[15:0]=16'h6261, guess_len=2.
REQ-030 guess_ready held 0 for 5 cycles during RUN -> guess unchanged and guess_valid=1 throughout; guess_count unchanged.
REQ-031 start and stop asserted in the same cycle during IDLE -> stays IDLE, guess_valid=0. stop during RUN -> IDLE next cycle.
REQ-032 n_rst asserted mid-RUN -> all outputs 0 asynchronously; after release, start -> first guess is "a", len 1.
REQ-033 GENERATE_GUESS_SEED_EN defined, seed "cb" (bytes 8'h63,8'h62), len 2, then start -> first guess "cb", next "ac"; with seed char 8'h7A the stored char becomes 8'h61.
